// File: rtl/adders_pkg.sv
// Shared definitions for the nibble-sliced arithmetic blocks.
//   NIB     : slice width in bits processed per clock
//   state_t : sequencing FSM encoding (IDLE, RUN, DONE)
package adders_pkg;

   localparam int NIB = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/four_bit_subtractor.sv
// Combinational 4-bit subtract slice: {bo, d} = {0,a} - {0,b} - bi.
// Ports:
//   a  : minuend nibble
//   b  : subtrahend nibble
//   bi : borrow in
//   d  : difference nibble
//   bo : borrow out (set when a < b + bi)
module four_bit_subtractor
   import adders_pkg::*;
(
   input  logic [NIB-1:0] a,
   input  logic [NIB-1:0] b,
   input  logic           bi,
   output logic [NIB-1:0] d,
   output logic           bo
);

   logic [NIB:0] res;

   // The extra top bit of the widened subtraction is exactly the borrow.
   assign res = {1'b0, a} - {1'b0, b} - {{NIB{1'b0}}, bi};
   assign d   = res[NIB-1:0];
   assign bo  = res[NIB];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor D = A - B - bin, one nibble per clock,
// least-significant nibble first, with a registered borrow between nibbles.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, sampled only when busy=0
//   A, B  : minuend / subtrahend, captured on accepted start
//   bin   : borrow in, captured on accepted start
//   busy  : high while nibbles are being processed
//   done  : one-cycle pulse; D/bout/ovf valid from this cycle onward
//   D     : (A - B - bin) mod 2^WIDTH
//   bout  : unsigned borrow out
//   ovf   : signed overflow
module nibble_serial_subtractor
   import adders_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / NIB;
   localparam int CW = $clog2(N) + 1;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, d_reg, d_next;
   logic [CW-1:0]    cnt_reg;
   logic             borrow_reg, bout_reg, ovf_reg;
   logic [NIB-1:0]   nib_d;
   logic             nib_bo;
   logic             accept, last_step;

   // Operands are shifted right each step, so the active nibble is always the low one.
   four_bit_subtractor u_slice (
      .a  (a_reg[NIB-1:0]),
      .b  (b_reg[NIB-1:0]),
      .bi (borrow_reg),
      .d  (nib_d),
      .bo (nib_bo)
   );

   // start is ignored only while RUN; DONE accepts it for back-to-back runs.
   assign accept    = start && (state_reg != RUN);
   assign last_step = (cnt_reg == CW'(N - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result fills from the top: after N steps the first nibble has reached bit 0.
   always_comb begin
      d_next                = d_reg >> NIB;
      d_next[WIDTH-1 -: NIB] = nib_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         d_reg      <= '0;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
         bout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else if (accept) begin
         a_reg      <= A;
         b_reg      <= B;
         borrow_reg <= bin;
         cnt_reg    <= '0;
         d_reg      <= '0;
         bout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else if (state_reg == RUN) begin
         a_reg      <= a_reg >> NIB;
         b_reg      <= b_reg >> NIB;
         d_reg      <= d_next;
         borrow_reg <= nib_bo;
         cnt_reg    <= cnt_reg + CW'(1);
         if (last_step) begin
            bout_reg <= nib_bo;
            // Borrow into the MSB is recovered from the sum bit: d3 = a3 ^ b3 ^ borrow_in3.
            ovf_reg  <= (a_reg[NIB-1] ^ b_reg[NIB-1] ^ nib_d[NIB-1]) ^ nib_bo;
         end
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign D    = d_reg;
   assign bout = bout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start8 = 1'b0, bin8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, bout8, ovf8;
   logic [7:0]  d8;
   logic        start16 = 1'b0, bin16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, bout16, ovf16;
   logic [15:0] d16;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   nibble_serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .bin(bin8),
      .busy(busy8), .done(done8), .D(d8), .bout(bout8), .ovf(ovf8)
   );

   nibble_serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .bin(bin16),
      .busy(busy16), .done(done16), .D(d16), .bout(bout16), .ovf(ovf16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent reference: widened unsigned difference plus signed range check.
   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
      logic [8:0] w;
      int s;
      w = {1'b0, a} - {1'b0, b} - {8'b0, bi};
      s = int'($signed(a)) - int'($signed(b)) - int'(bi);
      return {(s < -128 || s > 127), w[8], w[7:0]};
   endfunction

   function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic bi);
      logic [16:0] w;
      int s;
      w = {1'b0, a} - {1'b0, b} - {16'b0, bi};
      s = int'($signed(a)) - int'($signed(b)) - int'(bi);
      return {(s < -32768 || s > 32767), w[16], w[15:0]};
   endfunction

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo, input string tag);
      int n;
      a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
      n = 0;
      while (!done8 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd2);
      chk({tag, "_D"}, 32'(d8), 32'(ed));
      chk({tag, "_bout"}, 32'(bout8), 32'(eb));
      chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
      $display("%s: A=%h B=%h bin=%b -> D=%h bout=%b ovf=%b", tag, a, b, bi, d8, bout8, ovf8);
      @(posedge clk); #1;
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bi, input string tag);
      int n;
      logic [17:0] e;
      e = model16(a, b, bi);
      a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd4);
      chk({tag, "_D"}, 32'(d16), 32'(e[15:0]));
      chk({tag, "_bout"}, 32'(bout16), 32'(e[16]));
      chk({tag, "_ovf"}, 32'(ovf16), 32'(e[17]));
      $display("%s: A=%h B=%h bin=%b -> D=%h bout=%b ovf=%b", tag, a, b, bi, d16, bout16, ovf16);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [9:0] e;
      int dcount;
      bit bt;

      // Reset state
      #2;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_D", 32'(d8), 32'd0);
      chk("rst_bout", 32'(bout8), 32'd0);
      chk("rst_ovf", 32'(ovf8), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors
      run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "t1_0m1");
      chk("t1_hold_D", 32'(d8), 32'hFF);
      chk("t1_hold_done", 32'(done8), 32'd0);
      run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t2_ovf");
      run8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "t3_nibborrow");
      run8(8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0, 1'b0, "t3_bin");

      // start held six edges with changing operands: runs accepted at edges k and k+3
      a8 = 8'h11; b8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;                 // k
      a8 = 8'h33; b8 = 8'h44;
      @(posedge clk); #1;                 // k+1
      chk("t4_nodone1", 32'(done8), 32'd0);
      a8 = 8'h55; b8 = 8'h66;
      @(posedge clk); #1;                 // k+2
      chk("t4_done1", 32'(done8), 32'd1);
      chk("t4_D1", 32'(d8), 32'hEF);
      chk("t4_bout1", 32'(bout8), 32'd1);
      $display("t4_run1: A=11 B=22 bin=0 -> D=%h bout=%b", d8, bout8);
      a8 = 8'h77; b8 = 8'h01;
      @(posedge clk); #1;                 // k+3
      chk("t4_b2b_busy", 32'(busy8), 32'd1);
      chk("t4_nodone2", 32'(done8), 32'd0);
      a8 = 8'h99; b8 = 8'h12;
      @(posedge clk); #1;                 // k+4
      chk("t4_nodone3", 32'(done8), 32'd0);
      a8 = 8'hAB;
      @(posedge clk); #1;                 // k+5
      chk("t4_done2", 32'(done8), 32'd1);
      chk("t4_D2", 32'(d8), 32'h76);
      $display("t4_run2: A=77 B=01 bin=0 -> D=%h bout=%b", d8, bout8);
      start8 = 1'b0;
      @(posedge clk); #1;
      chk("t4_idle_busy", 32'(busy8), 32'd0);
      chk("t4_idle_done", 32'(done8), 32'd0);

      // Reset during RUN aborts the run
      a8 = 8'h50; b8 = 8'h21; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_busy", 32'(busy8), 32'd0);
      chk("t5_rst_done", 32'(done8), 32'd0);
      chk("t5_rst_D", 32'(d8), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done8) dcount++;
      end
      chk("t5_no_done", 32'(dcount), 32'd0);
      $display("t5_abort: reset during RUN, done pulses=%0d", dcount);
      run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "t5_after");

      // Coarse sweep with bin toggling, checked against the reference model
      bt = 1'b0;
      for (int a = 0; a < 256; a += 51) begin
         for (int b = 0; b < 256; b += 51) begin
            e = model8(8'(a), 8'(b), bt);
            run8(8'(a), 8'(b), bt, e[7:0], e[8], e[9], "t6_sweep");
            bt = ~bt;
         end
      end

      // 16-bit instance: corner plus random vectors
      run16(16'h0000, 16'h0001, 1'b0, "t6w_0m1");
      run16(16'h8000, 16'h0001, 1'b0, "t6w_ovf");
      for (int i = 0; i < 8; i++) begin
         run16(16'($urandom), 16'($urandom), 1'($urandom), "t6w_rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
